// File: rtl/Bus_arb_pkg.sv
// Bus_arb_pkg: shared types and helpers for the OCP N-to-1 bus arbiter.
//   Master_id  : master index, wide enough for up to 8 masters
//   Arb_state  : arbiter FSM states
//   rr_pick()  : rotating-priority pick over the request vector
package Bus_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef logic [2:0] Master_id;

  typedef enum logic {S_ARB, S_HOLD} Arb_state;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [1:0] RESP_NULL = 2'd0;

  typedef struct packed {
    logic     valid;
    Master_id id;
  } Rr_pick;

  // First requesting index searching ptr, ptr+1, ... mod n. The loop runs
  // downward so the last hit (smallest offset from ptr) wins.
  function automatic Rr_pick rr_pick(input logic [MAX_MASTERS-1:0] req,
                                     input Master_id ptr, input int n);
    Rr_pick p;
    int     idx;
    p.valid = 1'b0;
    p.id    = '0;
    for (int k = MAX_MASTERS - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[2:0]]) begin
          p.valid = 1'b1;
          p.id    = idx[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: synchronous FIFO holding the master ID of every command the
// slave has accepted but not yet answered.
//   Clk, MReset_n : clock, synchronous active-low reset (pointers/count only)
//   push, din     : write an ID
//   pop, dout     : retire the head ID; dout is the current head
//   full, empty   : occupancy flags
module arb_id_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             MReset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge Clk) begin
    if (!MReset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge Clk) disable iff (!MReset_n) !(push && full));
  a_no_pop_empty: assert property (@(posedge Clk) disable iff (!MReset_n) !(pop && empty));
`endif

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master to 1-slave OCP arbiter. One command is granted per
// slave accept; responses are routed back in order through an ID FIFO.
//   Clk, MReset_n                 : clock, synchronous active-low reset
//   m_MCmd/MAddr/MData/MDataValid/MByteEn : per-master command slices
//   m_SCmdAccept                  : accept to the granted master only
//   m_SResp, m_SData              : per-master response, broadcast data
//   m_MRespAccept                 : per-master response accept
//   s_*                           : single slave port
// Macro BUS_ARBITER_FIXED_PRIO_EN: lowest requesting index always wins
// (no rotating pointer). Undefined: round-robin per accepted command.
module bus_arbiter
  import Bus_arb_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              Clk,
  input  logic                              MReset_n,
  input  logic [N_MASTERS*3-1:0]            m_MCmd,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_MAddr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_MData,
  input  logic [N_MASTERS-1:0]              m_MDataValid,
  input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_MByteEn,
  output logic [N_MASTERS-1:0]              m_SCmdAccept,
  output logic [N_MASTERS*2-1:0]            m_SResp,
  output logic [DATA_WIDTH-1:0]             m_SData,
  input  logic [N_MASTERS-1:0]              m_MRespAccept,
  output logic [2:0]                        s_MCmd,
  output logic [ADDR_WIDTH-1:0]             s_MAddr,
  output logic [DATA_WIDTH-1:0]             s_MData,
  output logic                              s_MDataValid,
  output logic [DATA_WIDTH/8-1:0]           s_MByteEn,
  input  logic                              s_SCmdAccept,
  input  logic [1:0]                        s_SResp,
  input  logic [DATA_WIDTH-1:0]             s_SData,
  output logic                              s_MRespAccept
);

  localparam int BE_W = DATA_WIDTH / 8;

  Arb_state               state, state_nxt;
  Master_id               gnt, sel, head;
  Rr_pick                 pick;
  logic [MAX_MASTERS-1:0] req;
  logic                   drive, push, pop, full, empty;

  always_comb begin
    req = '0;
    for (int i = 0; i < N_MASTERS; i++) req[i] = (m_MCmd[i*3 +: 3] != CMD_IDLE);
  end

`ifdef BUS_ARBITER_FIXED_PRIO_EN
  always_comb pick = rr_pick(req, '0, N_MASTERS);
`else
  Master_id rr_ptr;
  always_comb pick = rr_pick(req, rr_ptr, N_MASTERS);
`endif

  // A held command keeps the port regardless of other requests; a fresh
  // grant needs FIFO room so S_HOLD can never overflow it.
  always_comb begin
    state_nxt = state;
    sel       = gnt;
    drive     = 1'b0;
    if (state == S_HOLD) begin
      drive = 1'b1;
      if (s_SCmdAccept) state_nxt = S_ARB;
    end else if (pick.valid && !full) begin
      sel   = pick.id;
      drive = 1'b1;
      if (!s_SCmdAccept) state_nxt = S_HOLD;
    end
  end

  assign push = drive && s_SCmdAccept;

  always_comb begin
    s_MCmd       = CMD_IDLE;
    s_MAddr      = '0;
    s_MData      = '0;
    s_MDataValid = 1'b0;
    s_MByteEn    = '0;
    m_SCmdAccept = '0;
    if (drive) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (sel == Master_id'(i)) begin
          s_MCmd          = m_MCmd[i*3 +: 3];
          s_MAddr         = m_MAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          s_MData         = m_MData[i*DATA_WIDTH +: DATA_WIDTH];
          s_MDataValid    = m_MDataValid[i];
          s_MByteEn       = m_MByteEn[i*BE_W +: BE_W];
          m_SCmdAccept[i] = s_SCmdAccept;
        end
      end
    end
  end

  // With nothing outstanding a stray response is drained (accepted and
  // dropped); with an idle slave the accept stays low.
  always_comb begin
    m_SResp       = '0;
    m_SData       = s_SData;
    s_MRespAccept = (s_SResp != RESP_NULL);
    if (!empty) begin
      s_MRespAccept = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
        if (head == Master_id'(i)) begin
          m_SResp[i*2 +: 2] = s_SResp;
          s_MRespAccept     = m_MRespAccept[i];
        end
      end
    end
  end

  assign pop = !empty && (s_SResp != RESP_NULL) && s_MRespAccept;

  always_ff @(posedge Clk) begin
    if (!MReset_n) begin
      state <= S_ARB;
      gnt   <= '0;
`ifndef BUS_ARBITER_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_ARB && drive && !s_SCmdAccept) gnt <= sel;
`ifndef BUS_ARBITER_FIXED_PRIO_EN
      if (push) rr_ptr <= (sel == Master_id'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
`endif
    end
  end

  arb_id_fifo #(
    .WIDTH ($bits(Master_id)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .Clk      (Clk),
    .MReset_n (MReset_n),
    .push     (push),
    .din      (sel),
    .pop      (pop),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );

`ifndef SYNTHESIS
  a_gnt_stable: assert property (@(posedge Clk) disable iff (!MReset_n)
    (state == S_HOLD && state_nxt == S_HOLD) |=> $stable(gnt));
  a_resp_when_empty: assert property (@(posedge Clk) disable iff (!MReset_n)
    !(empty && s_SResp != RESP_NULL));
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed-vector bench for bus_arbiter with two masters and
// a four-deep ID FIFO. Inputs change 1 time unit after the rising edge and
// outputs are compared 1 unit later, well before the next edge.
// Build with BUS_ARBITER_FIXED_PRIO_EN to exercise fixed priority instead.
module tb_bus_arbiter;

  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD = 3'd2;
  localparam logic [1:0] NUL = 2'd0, DVA = 2'd1;

  logic        Clk = 1'b0;
  logic        MReset_n;
  logic [5:0]  m_MCmd;
  logic [63:0] m_MAddr;
  logic [63:0] m_MData;
  logic [1:0]  m_MDataValid;
  logic [7:0]  m_MByteEn;
  logic [1:0]  m_SCmdAccept;
  logic [3:0]  m_SResp;
  logic [31:0] m_SData;
  logic [1:0]  m_MRespAccept;
  logic [2:0]  s_MCmd;
  logic [31:0] s_MAddr;
  logic [31:0] s_MData;
  logic        s_MDataValid;
  logic [3:0]  s_MByteEn;
  logic        s_SCmdAccept;
  logic [1:0]  s_SResp;
  logic [31:0] s_SData;
  logic        s_MRespAccept;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  bus_arbiter #(
    .N_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .Clk           (Clk),
    .MReset_n      (MReset_n),
    .m_MCmd        (m_MCmd),
    .m_MAddr       (m_MAddr),
    .m_MData       (m_MData),
    .m_MDataValid  (m_MDataValid),
    .m_MByteEn     (m_MByteEn),
    .m_SCmdAccept  (m_SCmdAccept),
    .m_SResp       (m_SResp),
    .m_SData       (m_SData),
    .m_MRespAccept (m_MRespAccept),
    .s_MCmd        (s_MCmd),
    .s_MAddr       (s_MAddr),
    .s_MData       (s_MData),
    .s_MDataValid  (s_MDataValid),
    .s_MByteEn     (s_MByteEn),
    .s_SCmdAccept  (s_SCmdAccept),
    .s_SResp       (s_SResp),
    .s_SData       (s_SData),
    .s_MRespAccept (s_MRespAccept)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c1, input logic [2:0] c0);
    m_MCmd = {c1, c0};
  endtask

  // Expected per-master response vector: DVA on the slot of master h.
  function automatic logic [3:0] resp_to(input int h);
    return (h == 0) ? 4'b0001 : 4'b0100;
  endfunction

  function automatic logic [31:0] addr_of(input int m);
    return (m == 0) ? 32'h0000_0100 : 32'h0000_0200;
  endfunction

  initial begin
    MReset_n      = 1'b0;
    m_MCmd        = '0;
    m_MAddr       = {32'h0000_0200, 32'h0000_0100};
    m_MData       = {32'hDA7A_0001, 32'hDA7A_0000};
    m_MDataValid  = 2'b00;
    m_MByteEn     = 8'h3C;
    m_MRespAccept = 2'b11;
    s_SCmdAccept  = 1'b0;
    s_SResp       = NUL;
    s_SData       = '0;
    tick();
    tick();
    #1;
    check_vec("rst_s_MCmd", 64'(s_MCmd), 64'(IDLE));
    check_vec("rst_m_SCmdAccept", 64'(m_SCmdAccept), 64'd0);
    check_vec("rst_m_SResp", 64'(m_SResp), 64'd0);
    check_vec("rst_s_MRespAccept", 64'(s_MRespAccept), 64'd0);

    MReset_n     = 1'b1;
    cmd(RD, RD);
    s_SCmdAccept = 1'b1;

`ifdef BUS_ARBITER_FIXED_PRIO_EN
    // Master0 wins every cycle while requesting; responses all go to it.
    for (int k = 0; k < 4; k++) begin
      s_SResp = (k > 0) ? DVA : NUL;
      s_SData = 32'hF000 + 32'(k);
      #1;
      check_vec("fp_acc", 64'(m_SCmdAccept), 64'd1);
      check_vec("fp_addr", 64'(s_MAddr), 64'(addr_of(0)));
      if (k > 0) check_vec("fp_resp", 64'(m_SResp), 64'(resp_to(0)));
      tick();
    end
    cmd(RD, IDLE);
    s_SResp = DVA;
    #1;
    check_vec("fp_m1_acc", 64'(m_SCmdAccept), 64'd2);
    check_vec("fp_m1_addr", 64'(s_MAddr), 64'(addr_of(1)));
    check_vec("fp_resp_m0", 64'(m_SResp), 64'(resp_to(0)));
    tick();
    cmd(IDLE, IDLE);
    #1;
    check_vec("fp_resp_m1", 64'(m_SResp), 64'(resp_to(1)));
    tick();
    s_SResp = NUL;
    #1;
    check_vec("fp_idle_racc", 64'(s_MRespAccept), 64'd0);
`else
    // Round robin, slave accepts at once and answers one cycle later.
    for (int k = 0; k < 4; k++) begin
      s_SResp = (k > 0) ? DVA : NUL;
      s_SData = 32'hA000 + 32'(k);
      #1;
      check_vec("rr_acc", 64'(m_SCmdAccept), (k % 2 == 0) ? 64'd1 : 64'd2);
      check_vec("rr_addr", 64'(s_MAddr), 64'(addr_of(k % 2)));
      check_vec("rr_cmd", 64'(s_MCmd), 64'(RD));
      if (k > 0) begin
        check_vec("rr_resp", 64'(m_SResp), 64'(resp_to((k - 1) % 2)));
        check_vec("rr_sdata", 64'(m_SData), 64'(32'hA000 + 32'(k)));
        check_vec("rr_racc", 64'(s_MRespAccept), 64'd1);
      end
      tick();
    end
    cmd(IDLE, IDLE);
    s_SResp = DVA;
    #1;
    check_vec("rr_last_resp", 64'(m_SResp), 64'(resp_to(1)));
    check_vec("rr_idle_cmd", 64'(s_MCmd), 64'(IDLE));
    check_vec("rr_idle_acc", 64'(m_SCmdAccept), 64'd0);
    tick();
    s_SResp = NUL;
    #1;
    check_vec("rr_empty_racc", 64'(s_MRespAccept), 64'd0);

    // Master1 held for three refused cycles while master0 also requests.
    cmd(RD, IDLE);
    s_SCmdAccept = 1'b0;
    #1;
    check_vec("hold_cmd", 64'(s_MCmd), 64'(RD));
    check_vec("hold_addr0", 64'(s_MAddr), 64'(addr_of(1)));
    check_vec("hold_acc0", 64'(m_SCmdAccept), 64'd0);
    tick();
    cmd(RD, RD);
    for (int c = 0; c < 2; c++) begin
      #1;
      check_vec("hold_addr", 64'(s_MAddr), 64'(addr_of(1)));
      check_vec("hold_acc", 64'(m_SCmdAccept), 64'd0);
      tick();
    end
    s_SCmdAccept = 1'b1;
    #1;
    check_vec("hold_m1_acc", 64'(m_SCmdAccept), 64'd2);
    check_vec("hold_m1_addr", 64'(s_MAddr), 64'(addr_of(1)));
    tick();
    cmd(IDLE, RD);
    #1;
    check_vec("hold_m0_acc", 64'(m_SCmdAccept), 64'd1);
    check_vec("hold_m0_addr", 64'(s_MAddr), 64'(addr_of(0)));
    tick();
    cmd(IDLE, IDLE);
    s_SResp = DVA;
    s_SData = 32'hB001;
    #1;
    check_vec("hold_resp_m1", 64'(m_SResp), 64'(resp_to(1)));
    check_vec("hold_sdata", 64'(m_SData), 64'h0000_B001);
    tick();
    s_SData = 32'hB000;
    #1;
    check_vec("hold_resp_m0", 64'(m_SResp), 64'(resp_to(0)));
    tick();
    s_SResp = NUL;

    // FIFO full: rr_ptr=1 so the order is M1,M0,M1,M0, then no grant.
    cmd(WR, WR);
    m_MDataValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec("full_acc", 64'(m_SCmdAccept), (k % 2 == 0) ? 64'd2 : 64'd1);
      tick();
    end
    #1;
    check_vec("full_block_acc", 64'(m_SCmdAccept), 64'd0);
    check_vec("full_block_cmd", 64'(s_MCmd), 64'(IDLE));
    tick();
    s_SResp = DVA;
    s_SData = 32'hC001;
    #1;
    check_vec("full_pop_acc", 64'(m_SCmdAccept), 64'd0);
    check_vec("full_pop_resp", 64'(m_SResp), 64'(resp_to(1)));
    check_vec("full_pop_racc", 64'(s_MRespAccept), 64'd1);
    tick();
    s_SResp = NUL;
    #1;
    check_vec("full_5th_acc", 64'(m_SCmdAccept), 64'd2);
    check_vec("full_5th_cmd", 64'(s_MCmd), 64'(WR));
    check_vec("full_5th_data", 64'(s_MData), 64'hDA7A_0001);
    check_vec("full_5th_dv", 64'(s_MDataValid), 64'd1);
    check_vec("full_5th_be", 64'(s_MByteEn), 64'h3);
    tick();
    cmd(IDLE, IDLE);
    m_MDataValid = 2'b00;

    // FIFO is M0,M1,M0,M1. Head master refuses the response for two cycles.
    m_MRespAccept = 2'b10;
    s_SResp = DVA;
    s_SData = 32'hD000;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_vec("stall_racc", 64'(s_MRespAccept), 64'd0);
      check_vec("stall_resp", 64'(m_SResp), 64'(resp_to(0)));
      tick();
    end
    m_MRespAccept = 2'b11;
    #1;
    check_vec("stall_pop_racc", 64'(s_MRespAccept), 64'd1);
    tick();
    s_SData = 32'hD001;
    #1;
    check_vec("stall_next_resp", 64'(m_SResp), 64'(resp_to(1)));
    check_vec("stall_next_data", 64'(m_SData), 64'h0000_D001);
    tick();
    s_SResp = NUL;

    // Push rr_ptr to 1 with three outstanding, then reset.
    cmd(IDLE, RD);
    #1;
    check_vec("pre_rst_acc", 64'(m_SCmdAccept), 64'd1);
    tick();
    cmd(IDLE, IDLE);
    MReset_n = 1'b0;
    tick();
    MReset_n = 1'b1;
    #1;
    check_vec("post_rst_cmd", 64'(s_MCmd), 64'(IDLE));
    check_vec("post_rst_resp", 64'(m_SResp), 64'd0);
    check_vec("post_rst_racc", 64'(s_MRespAccept), 64'd0);
    // rr_ptr back at 0 and four free FIFO slots.
    cmd(RD, RD);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec("post_rst_acc", 64'(m_SCmdAccept), (k % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    #1;
    check_vec("post_rst_full", 64'(m_SCmdAccept), 64'd0);
    cmd(IDLE, IDLE);
    s_SResp = DVA;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec("post_rst_drain", 64'(m_SResp), 64'(resp_to(k % 2)));
      tick();
    end
    s_SResp = NUL;
    #1;
    check_vec("final_racc", 64'(s_MRespAccept), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
